// File: rtl/alu_mdu_exec.sv
// Purpose  : RV32I ALU plus M-extension (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU) execute unit.
// Latency  : base ops 1 cycle; M ops XLEN+1 cycles; divide-by-zero / signed overflow 2 cycles.
// Backpress: in_ready drops while an M op is in flight; out_valid is a single-cycle pulse, never stalled.
// Ports    : clk, reset (sync, active-high); in_valid/in_ready issue handshake;
//            ALUOp/funct3/funct7b5/funct7b0/op5 decode; a, b operands;
//            out_valid/result response (result holds until next out_valid); busy = ~in_ready.
module alu_mdu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            op5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [2*XLEN-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opb;       // multiplicand magnitude or divisor magnitude
  logic [SHW-1:0]    count;
  logic [2:0]        f3_q;
  logic              neg_q;     // sign of product / quotient
  logic              neg_r;     // sign of remainder (follows dividend)
  logic              spec_q;    // divide special case: answer already sits in acc low half
  logic              base_vld_q;

  logic accept, is_m, last;
  assign accept = in_valid & in_ready;
  assign is_m   = (ALUOp == 2'b10) & op5 & funct7b0;
  assign last   = (count == SHW'(XLEN-1));

  // ---------------- base ALU ----------------
  logic [XLEN-1:0] alu_r;
  always_comb begin
    alu_r = a + b;
    if (ALUOp == 2'b01) begin
      alu_r = a - b;
    end else if (ALUOp == 2'b10) begin
      case (funct3)
        3'b000: alu_r = (funct7b5 & op5) ? a - b : a + b;
        3'b001: alu_r = a << b[SHW-1:0];
        3'b010: alu_r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        3'b011: alu_r = {{(XLEN-1){1'b0}}, a < b};
        3'b100: alu_r = a ^ b;
        3'b101: alu_r = funct7b5 ? XLEN'($signed(a) >>> b[SHW-1:0]) : a >> b[SHW-1:0];
        3'b110: alu_r = a | b;
        default: alu_r = a & b;
      endcase
    end
  end

  // ---------------- M-op operand preparation ----------------
  logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, spec;
  logic [XLEN-1:0] a_mag, b_mag, spec_val, min_val;
  always_comb begin
    // div group: DIV/REM signed (f3[0]=0); mul group: MULH signed both, MULHSU signed a only
    a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
    b_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_sgn & a[XLEN-1];
    b_neg    = b_sgn & b[XLEN-1];
    a_mag    = a_neg ? ~a + 1'b1 : a;
    b_mag    = b_neg ? ~b + 1'b1 : b;
    min_val  = {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b == '0);
    div_ovf  = ~funct3[0] & (a == min_val) & (b == '1);
    spec     = funct3[2] & (div_zero | div_ovf);
    if (funct3[1]) spec_val = div_zero ? a : '0;        // REM/REMU
    else           spec_val = div_zero ? '1 : min_val;  // DIV/DIVU
  end

  // ---------------- iteration step and final sign fix ----------------
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_acc_nx, div_acc_nx, prod_fix;
  logic [XLEN-1:0]   mul_res, div_res, quo, rem;
  always_comb begin
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : {XLEN{1'b0}})};
    mul_acc_nx = {mul_sum, acc[XLEN-1:1]};
    // trial subtract of the divisor from the left-shifted partial remainder
    div_trial  = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
    div_acc_nx = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod_fix   = neg_q ? ~mul_acc_nx + 1'b1 : mul_acc_nx;
    mul_res    = (f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    quo        = div_acc_nx[XLEN-1:0];
    rem        = div_acc_nx[2*XLEN-1:XLEN];
    if (f3_q[1]) div_res = neg_r ? ~rem + 1'b1 : rem;
    else         div_res = neg_q ? ~quo + 1'b1 : quo;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept & is_m) state_nx = funct3[2] ? DIV : MUL;
      MUL:  if (last) state_nx = DONE;
      // special cases spend a single pass through DIV instead of iterating
      DIV:  if (spec_q | last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = ~in_ready;
    out_valid = (state == DONE) | base_vld_q;
  end

  // ---------------- datapath ----------------
  // The signed result is registered on the edge entering DONE so that result is
  // already stable during the out_valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0; opb <= '0; count <= '0; f3_q <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; spec_q <= 1'b0;
      base_vld_q <= 1'b0; result <= '0;
    end else begin
      base_vld_q <= accept & ~is_m;
      case (state)
        IDLE: if (accept) begin
          if (!is_m) begin
            result <= alu_r;
          end else begin
            f3_q   <= funct3;
            count  <= '0;
            opb    <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            spec_q <= spec;
            acc    <= {{XLEN{1'b0}}, spec ? spec_val : a_mag};
          end
        end
        MUL: begin
          acc   <= mul_acc_nx;
          count <= count + 1'b1;
          if (last) result <= mul_res;
        end
        DIV: begin
          if (spec_q) begin
            result <= acc[XLEN-1:0];
          end else begin
            acc   <= div_acc_nx;
            count <= count + 1'b1;
            if (last) result <= div_res;
          end
        end
        default: begin
          spec_q <= 1'b0;
          count  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu_exec.sv
// Purpose  : directed-vector bench for alu_mdu_exec with a queue scoreboard and independent monitor.
// Latency  : each expectation carries the cycle at which out_valid must appear.
// Backpress: issue waits (bounded) for in_ready; stray out_valid pulses are flagged by the monitor.
module tb_alu_mdu_exec;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic        funct7b5, funct7b0, op5;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;
  logic        busy;

  alu_mdu_exec #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .op5(op5),
    .a(a), .b(b), .out_valid(out_valid), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // monitor: every out_valid pulse must match the oldest expectation in value and cycle
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: result=%h at cycle %0d, no response expected", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || cyc != e.at) begin
          errors++;
          $display("FAIL %s: got result=%h at cycle %0d, expected %h at cycle %0d",
                   e.name, result, cyc, e.res, e.at);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Presents one op; returns on the negedge just after the accepting edge.
  task automatic issue(input string nm, input logic [1:0] op, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0, input logic o5,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int lat, input bit want);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_in_ready_timeout: in_ready=%b, expected 1", nm, in_ready);
    end
    ALUOp = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; op5 = o5; a = av; b = bv;
    in_valid = 1'b1;
    if (want) sb.push_back('{exp, cyc + lat, nm});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; funct3 = 3'b000;
    funct7b5 = 1'b0; funct7b0 = 1'b0; op5 = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);

    // base ALU ops: latency 1
    issue("add",      2'b10, 3'b000, 0, 0, 1, 32'd5,          32'd7,          32'd12,         1, 1);
    issue("sra",      2'b10, 3'b101, 1, 0, 1, 32'h8000_0000,  32'd4,          32'hF800_0000,  1, 1);
    issue("srl",      2'b10, 3'b101, 0, 0, 1, 32'h8000_0000,  32'd4,          32'h0800_0000,  1, 1);
    issue("aluop_sub",2'b01, 3'b111, 0, 0, 1, 32'd10,         32'd3,          32'd7,          1, 1);
    issue("slt",      2'b10, 3'b010, 0, 0, 1, 32'hFFFF_FFFF,  32'd1,          32'd1,          1, 1);
    issue("sltu",     2'b10, 3'b011, 0, 0, 1, 32'hFFFF_FFFF,  32'd1,          32'd0,          1, 1);
    issue("sll_shamt",2'b10, 3'b001, 0, 0, 1, 32'd1,          32'h0000_003F,  32'h8000_0000,  1, 1);
    issue("xor",      2'b10, 3'b100, 0, 0, 1, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1, 1);
    issue("or",       2'b10, 3'b110, 0, 0, 1, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1, 1);
    issue("and",      2'b10, 3'b111, 0, 0, 1, 32'h0000_00FF,  32'h0000_003C,  32'h0000_003C,  1, 1);
    issue("addi_f7b5",2'b10, 3'b000, 1, 0, 0, 32'd5,          32'd7,          32'd12,         1, 1);
    issue("aluop11",  2'b11, 3'b101, 1, 1, 1, 32'd3,          32'd4,          32'd7,          1, 1);
    issue("itype_m",  2'b10, 3'b000, 0, 1, 0, 32'd2,          32'd3,          32'd5,          1, 1);
    issue("sub_wrap", 2'b10, 3'b000, 1, 0, 1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1, 1);

    // MULHU with busy / in_ready window checks
    issue("mulhu",    2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF,  32'd2,          32'd1,          33, 1);
    chk("mulhu_in_ready_c1", {31'd0, in_ready}, 32'd0);
    chk("mulhu_busy_c1", {31'd0, busy}, 32'd1);
    repeat (31) @(negedge clk);
    chk("mulhu_in_ready_c32", {31'd0, in_ready}, 32'd0);

    // MUL while a foreign op is held on the inputs during busy
    issue("mul",      2'b10, 3'b000, 0, 1, 1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  33, 1);
    ALUOp = 2'b00; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;

    issue("mulh",     2'b10, 3'b001, 0, 1, 1, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33, 1);
    issue("mulhsu",   2'b10, 3'b010, 0, 1, 1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, 1);
    issue("div",      2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1);
    issue("rem",      2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1);
    issue("divu",     2'b10, 3'b101, 0, 1, 1, 32'd100,        32'd7,          32'd14,         33, 1);
    issue("remu",     2'b10, 3'b111, 0, 1, 1, 32'd100,        32'd7,          32'd2,          33, 1);
    issue("divu_big", 2'b10, 3'b101, 0, 1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 1);

    // division special cases: latency 2
    issue("divu_by0", 2'b10, 3'b101, 0, 1, 1, 32'd55,         32'd0,          32'hFFFF_FFFF,  2, 1);
    issue("remu_by0", 2'b10, 3'b111, 0, 1, 1, 32'h0000_1234,  32'd0,          32'h0000_1234,  2, 1);
    issue("div_by0",  2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  2, 1);
    issue("rem_by0",  2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  2, 1);
    issue("rem_ovf",  2'b10, 3'b110, 0, 1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2, 1);
    issue("div_ovf",  2'b10, 3'b100, 0, 1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2, 1);

    // reset in the middle of a DIV: no response, clean restart
    issue("div_abort",2'b10, 3'b101, 0, 1, 1, 32'd100,        32'd7,          32'd0,          33, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    issue("add_after_reset", 2'b10, 3'b000, 0, 0, 1, 32'd1, 32'd1, 32'd2, 1, 1);

    begin
      int w = 0;
      while (sb.size() != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
